video_rd_prefetch: RTL and testbench
====================================

# video_rd_prefetch

Frame-buffer read scheduler between the memory read port and the line FIFO that feeds the video timing driver. At each frame start it flushes the line FIFO and rewinds to the frame base address. It then issues burst read requests whenever the FIFO has room for a full burst, and counts FIFO underflows seen by the display side. All logic runs in the pixel clock domain.

## Interface
Parameters:
- H_DISP, 1024 — active pixels per line
- V_DISP, 768 — active lines per frame
- BURST_LEN, 64 — maximum words per read burst (1..256)
- FIFO_DEPTH, 2048 — line FIFO capacity in words
- AW, 24 — memory word-address width

Ports (one clock; reset is synchronous and active-high):
- pixel_clk  in  1  pixel clock; all state updates on rising edge
- sys_rst  in  1  synchronous active-high reset
- video_vs  in  1  vertical sync from timing driver, active low
- data_req  in  1  display pixel request (FIFO read strobe)
- fifo_empty  in  1  line FIFO empty flag
- fifo_used  in  12  line FIFO fill level in words
- frame_base  in  AW  frame-buffer base word address
- rd_req  out  1  burst read request
- rd_addr  out  AW  burst start word address
- rd_len  out  9  burst length in words
- rd_ack  in  1  memory accepted request
- rd_valid  in  1  one read data word delivered to the FIFO
- fifo_clr  out  1  one-cycle FIFO flush pulse
- frame_start  out  1  one-cycle pulse when a frame restart is applied
- busy  out  1  high in REQ or DATA
- underflow_cnt  out  16  saturating underflow count

## Operation
- Frame-start event: `vs_q` holds `video_vs` registered. The event is `vs_q==1 && video_vs==0` (falling edge).
- Restart action, one cycle:
  - `fifo_clr=1` and `frame_start=1`.
  - `addr <= frame_base`.
  - `remaining <= H_DISP*V_DISP` (21-bit).
  - Go to FILL.
- State machine:
  - **IDLE**: state after reset. Waits for a frame-start event, then performs the restart action.
  - **FILL**:
    - If `remaining==0`, go to DONE.
    - Else if `fifo_used + BURST_LEN <= FIFO_DEPTH`, latch `rd_addr<=addr` and `rd_len<=min(BURST_LEN,remaining)`, then go to REQ.
    - Otherwise stay in FILL.
  - **REQ**: `rd_req=1`, with `rd_addr` and `rd_len` held stable. When `rd_ack=1`, go to DATA and clear the beat counter.
  - **DATA**:
    - Each `rd_valid` increments the beat counter.
    - On the beat where the count reaches `rd_len`: `addr += rd_len` (wraps modulo 2^AW), `remaining -= rd_len`, go to FILL.
  - **DONE**: idle until the next frame-start event.
- Frame-start event in IDLE, FILL or DONE: restart immediately.
- Frame-start event in REQ or DATA: set `restart_pend`. The in-flight handshake and burst always complete; they are never abandoned.
  - On burst completion with `restart_pend` set, perform the restart action on that completion cycle instead of the normal address update, and clear `restart_pend`.
  - Further events while pending are absorbed.
- `rd_valid` outside DATA is ignored. `rd_ack` outside REQ is ignored.
- Underflow: `data_req && fifo_empty` increments `underflow_cnt`, saturating at 0xFFFF. It is cleared only by reset.
- Sizing: FIFO_DEPTH >= BURST_LEN. The 21-bit arithmetic covers frames up to 2^21-1 words.

## Timing
- Reset (sys_rst=1 at an edge): state=IDLE, `vs_q=1`, `restart_pend=0`, `addr=0`, `remaining=0`. Outputs are all zero: `rd_req`, `rd_addr`, `rd_len`, `fifo_clr`, `frame_start`, `busy`, `underflow_cnt`.
- `rd_req`, `busy`, `fifo_clr` and `frame_start` are registered and decoded from state; no combinational path from inputs to outputs.
- Frame-start latency: `fifo_clr` is high in the cycle after the edge that samples the `video_vs` falling edge, when the FSM is idle.
- Minimum idle-to-request latency: 2 cycles from the restart cycle (restart → FILL → REQ with `rd_req` visible).
- `rd_ack` may arrive in the first cycle `rd_req` is high. `rd_req` drops the cycle after `rd_ack` is sampled.
- Back-to-back bursts: one FILL cycle minimum between the last beat and the next `rd_req`.
- `fifo_used` is sampled in FILL only, so it does not include in-flight beats. This is safe because at most one burst is outstanding.

## Test plan
- **Reset**: hold sys_rst 3 cycles mid-burst → all outputs 0, state IDLE, and no `rd_req` until a `video_vs` falling edge.
- **Short frame**: H_DISP=100, V_DISP=2, BURST_LEN=64, frame_base=0x001000, immediate ack and beats.
  - Exactly 4 bursts, at addresses 0x001000, 0x001040, 0x001080, 0x0010C0, with lengths 64, 64, 64, 8.
  - Then DONE, with `rd_req` low until the next frame.
- **Backpressure**: FIFO_DEPTH=2048, `fifo_used`=1985 → no `rd_req`. Drop to 1984 → `rd_req` 2 cycles later.
- **Held request**: `rd_ack` withheld 20 cycles → `rd_req`, `rd_addr` and `rd_len` stay constant. Ack on cycle 21 → `rd_req` low next cycle.
- **Restart mid-burst**: `video_vs` falls after 10 of 64 beats.
  - Burst completes all 64 beats; `fifo_clr` and `frame_start` pulse on the 64th-beat cycle.
  - Next `rd_addr` equals the newly sampled `frame_base`.
- **Underflow**: 5 cycles of `data_req && fifo_empty` → `underflow_cnt`=5. Force 70000 events → count saturates at 0xFFFF.

Source files
------------

// File: rtl/video_rd_prefetch_if.sv
// Memory read-port bundle between the prefetch scheduler (master) and the memory controller (slave).
interface video_rd_prefetch_if #(
    parameter int unsigned AW = 24
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [8:0]    rd_len;
    logic          rd_ack;
    logic          rd_valid;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        input  rd_ack,
        input  rd_valid
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        output rd_ack,
        output rd_valid
    );
endinterface

// File: rtl/video_rd_prefetch.sv
// Frame-buffer read scheduler: rewinds at each frame start, issues burst reads while the
// line FIFO has room for a whole burst, and counts display-side FIFO underflows.
module video_rd_prefetch #(
    parameter int unsigned H_DISP     = 1024,
    parameter int unsigned V_DISP     = 768,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned AW         = 24
) (
    input  logic                 pixel_clk,
    input  logic                 sys_rst,
    input  logic                 video_vs,
    input  logic                 data_req,
    input  logic                 fifo_empty,
    input  logic [11:0]          fifo_used,
    input  logic [AW-1:0]        frame_base,
    video_rd_prefetch_if.master  mem,
    output logic                 fifo_clr,
    output logic                 frame_start,
    output logic                 busy,
    output logic [15:0]          underflow_cnt
);
    localparam int unsigned REM_W       = 21;
    localparam int unsigned LEN_W       = 9;
    localparam logic [REM_W-1:0] FRAME_WORDS = REM_W'(H_DISP * V_DISP);
    localparam logic [REM_W-1:0] BURST_REM   = REM_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               vs_q;
    logic               restart_pend_q, restart_pend_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]   rd_len_q, rd_len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               rd_req_q;
    logic               vs_fall_c;
    logic               room_c;
    logic               restart_c;

    assign vs_fall_c = vs_q & ~video_vs;
    // fifo_used excludes in-flight beats; safe because only one burst is ever outstanding
    assign room_c    = (32'(fifo_used) + BURST_LEN) <= FIFO_DEPTH;

    assign mem.rd_req  = rd_req_q;
    assign mem.rd_addr = rd_addr_q;
    assign mem.rd_len  = rd_len_q;

    // Next-state and datapath updates; a restart overrides whatever the state chose
    always_comb begin
        state_d        = state_q;
        restart_pend_d = restart_pend_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        rd_addr_d      = rd_addr_q;
        rd_len_d       = rd_len_q;
        beat_d         = beat_q;
        restart_c      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                restart_c = vs_fall_c;
            end
            S_FILL: begin
                if (vs_fall_c) begin
                    restart_c = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (room_c) begin
                    rd_addr_d = addr_q;
                    rd_len_d  = (remaining_q < BURST_REM) ? LEN_W'(remaining_q)
                                                          : LEN_W'(BURST_LEN);
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (vs_fall_c) restart_pend_d = 1'b1;
                if (mem.rd_ack) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vs_fall_c) restart_pend_d = 1'b1;
                if (mem.rd_valid) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_d == rd_len_q) begin
                        if (restart_pend_q || vs_fall_c) begin
                            restart_c = 1'b1;
                        end else begin
                            addr_d      = addr_q + AW'(rd_len_q);
                            remaining_d = remaining_q - REM_W'(rd_len_q);
                            state_d     = S_FILL;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart_c) begin
            addr_d         = frame_base;
            remaining_d    = FRAME_WORDS;
            restart_pend_d = 1'b0;
            state_d        = S_FILL;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q        <= S_IDLE;
            vs_q           <= 1'b1;
            restart_pend_q <= 1'b0;
            addr_q         <= '0;
            remaining_q    <= '0;
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            beat_q         <= '0;
            rd_req_q       <= 1'b0;
            busy           <= 1'b0;
            fifo_clr       <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_q           <= video_vs;
            restart_pend_q <= restart_pend_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            rd_addr_q      <= rd_addr_d;
            rd_len_q       <= rd_len_d;
            beat_q         <= beat_d;
            rd_req_q       <= (state_d == S_REQ);
            busy           <= (state_d == S_REQ) || (state_d == S_DATA);
            fifo_clr       <= restart_c;
            frame_start    <= restart_c;
        end
    end

    // Saturating underflow counter, cleared only by reset
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            underflow_cnt <= '0;
        end else if (data_req && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_video_rd_prefetch.sv
// Directed bench for video_rd_prefetch: 100x2 frame, 64-word bursts, 2048-word FIFO.
module tb_video_rd_prefetch;
    localparam int unsigned AW = 24;

    logic          pixel_clk;
    logic          sys_rst;
    logic          video_vs;
    logic          data_req;
    logic          fifo_empty;
    logic [11:0]   fifo_used;
    logic [AW-1:0] frame_base;
    logic          fifo_clr;
    logic          frame_start;
    logic          busy;
    logic [15:0]   underflow_cnt;

    int n_checks = 0;
    int n_errors = 0;

    video_rd_prefetch_if #(.AW(AW)) bus ();

    video_rd_prefetch #(
        .H_DISP(100), .V_DISP(2), .BURST_LEN(64), .FIFO_DEPTH(2048), .AW(AW)
    ) dut (
        .pixel_clk     (pixel_clk),
        .sys_rst       (sys_rst),
        .video_vs      (video_vs),
        .data_req      (data_req),
        .fifo_empty    (fifo_empty),
        .fifo_used     (fifo_used),
        .frame_base    (frame_base),
        .mem           (bus),
        .fifo_clr      (fifo_clr),
        .frame_start   (frame_start),
        .busy          (busy),
        .underflow_cnt (underflow_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (bus.rd_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("req_wait", 32'(bus.rd_req), 1);
    endtask

    task automatic serve_burst(output logic [AW-1:0] a, output logic [8:0] l);
        wait_req(20);
        a = bus.rd_addr;
        l = bus.rd_len;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b1;
        repeat (l) tick();
        bus.rd_valid = 1'b0;
    endtask

    task automatic vs_fall();
        video_vs = 1'b0;
        tick();
        video_vs = 1'b1;
    endtask

    logic [AW-1:0] exp_addr [4];
    logic [8:0]    exp_len  [4];

    initial begin
        logic [AW-1:0] a;
        logic [8:0]    l;
        logic [AW-1:0] a0;
        logic [8:0]    l0;
        int            highs;

        exp_addr = '{24'h001000, 24'h001040, 24'h001080, 24'h0010C0};
        exp_len  = '{9'd64, 9'd64, 9'd64, 9'd8};

        sys_rst      = 1'b1;
        video_vs     = 1'b1;
        data_req     = 1'b0;
        fifo_empty   = 1'b0;
        fifo_used    = 12'd0;
        frame_base   = 24'h001000;
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        repeat (3) tick();

        check("rst_rd_req", 32'(bus.rd_req), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_rd_len", 32'(bus.rd_len), 0);
        check("rst_fifo_clr", 32'(fifo_clr), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underflow", 32'(underflow_cnt), 0);
        sys_rst = 1'b0;

        // Underflow counting only when both strobes coincide
        data_req   = 1'b1;
        fifo_empty = 1'b1;
        repeat (5) tick();
        data_req = 1'b0;
        check("uf_five", 32'(underflow_cnt), 5);
        repeat (3) tick();
        fifo_empty = 1'b0;
        data_req   = 1'b1;
        repeat (3) tick();
        data_req = 1'b0;
        check("uf_no_empty", 32'(underflow_cnt), 5);

        // No request before any frame start
        highs = 0;
        repeat (5) begin tick(); if (bus.rd_req) highs++; end
        check("idle_no_req", 32'(highs), 0);

        // Short frame: 200 words -> 64,64,64,8
        vs_fall();
        check("fs_fifo_clr", 32'(fifo_clr), 1);
        check("fs_frame_start", 32'(frame_start), 1);
        check("fs_rd_req_low", 32'(bus.rd_req), 0);
        tick();
        check("fs_req_latency", 32'(bus.rd_req), 1);
        check("fs_busy", 32'(busy), 1);
        check("fs_clr_pulse", 32'(fifo_clr), 0);
        for (int i = 0; i < 4; i++) begin
            serve_burst(a, l);
            check($sformatf("sf_addr%0d", i), 32'(a), 32'(exp_addr[i]));
            check($sformatf("sf_len%0d", i), 32'(l), 32'(exp_len[i]));
        end
        highs = 0;
        repeat (10) begin tick(); if (bus.rd_req || busy) highs++; end
        check("sf_done_quiet", 32'(highs), 0);

        // Backpressure: 1985 + 64 > 2048 blocks, 1984 allows
        fifo_used  = 12'd1985;
        frame_base = 24'h000200;
        vs_fall();
        check("bp_fifo_clr", 32'(fifo_clr), 1);
        highs = 0;
        repeat (10) begin tick(); if (bus.rd_req) highs++; end
        check("bp_blocked", 32'(highs), 0);
        fifo_used = 12'd1984;
        tick();
        tick();
        check("bp_req", 32'(bus.rd_req), 1);
        check("bp_addr", 32'(bus.rd_addr), 32'h000200);
        check("bp_len", 32'(bus.rd_len), 64);

        // Held request: no ack for 20 cycles
        a0 = bus.rd_addr;
        l0 = bus.rd_len;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rd_req !== 1'b1 || bus.rd_addr !== a0 || bus.rd_len !== l0) highs++;
        end
        check("hold_stable", 32'(highs), 0);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("hold_req_drop", 32'(bus.rd_req), 0);
        check("hold_busy", 32'(busy), 1);

        // Restart mid-burst: falling vs after 10 beats, burst still completes
        bus.rd_valid = 1'b1;
        repeat (10) tick();
        video_vs   = 1'b0;
        frame_base = 24'h00ABCD;
        tick();
        video_vs = 1'b1;
        check("mid_no_early_clr", 32'(fifo_clr), 0);
        repeat (52) tick();
        check("mid_beat63_busy", 32'(busy), 1);
        check("mid_beat63_clr", 32'(fifo_clr), 0);
        tick();
        bus.rd_valid = 1'b0;
        check("mid_clr", 32'(fifo_clr), 1);
        check("mid_frame_start", 32'(frame_start), 1);
        fifo_used = 12'd0;
        tick();
        check("mid_req", 32'(bus.rd_req), 1);
        check("mid_addr", 32'(bus.rd_addr), 32'h00ABCD);
        check("mid_len", 32'(bus.rd_len), 64);
        check("mid_clr_pulse", 32'(fifo_clr), 0);

        // Reset mid-burst
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack   = 1'b0;
        bus.rd_valid = 1'b1;
        repeat (5) tick();
        bus.rd_valid = 1'b0;
        sys_rst      = 1'b1;
        repeat (3) tick();
        check("mrst_rd_req", 32'(bus.rd_req), 0);
        check("mrst_rd_addr", 32'(bus.rd_addr), 0);
        check("mrst_rd_len", 32'(bus.rd_len), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_fifo_clr", 32'(fifo_clr), 0);
        check("mrst_frame_start", 32'(frame_start), 0);
        check("mrst_underflow", 32'(underflow_cnt), 0);
        sys_rst = 1'b0;
        highs = 0;
        repeat (10) begin tick(); if (bus.rd_req) highs++; end
        check("mrst_no_req", 32'(highs), 0);
        vs_fall();
        tick();
        check("mrst_restart_req", 32'(bus.rd_req), 1);
        check("mrst_restart_addr", 32'(bus.rd_addr), 32'h00ABCD);

        // Underflow saturation
        data_req   = 1'b1;
        fifo_empty = 1'b1;
        repeat (65534) tick();
        check("uf_fffe", 32'(underflow_cnt), 32'hFFFE);
        repeat (70000 - 65534) tick();
        data_req = 1'b0;
        check("uf_sat", 32'(underflow_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
